// File: rtl/spi_slave.sv
// spi_slave: SPI receive/transmit endpoint, oversampled in the clk domain.
// All SPI pins are synchronised and edge-detected; no logic is clocked by sclk.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on sclk/cs/mosi (minimum 2)
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   cpol, cpha          SPI mode, latched at transaction start
//   sclk, cs, mosi      SPI inputs from the master (cs active low)
//   miso                serial data out, MSB first, 0 when idle
//   tx_data, tx_load    one-deep transmit buffer write
//   tx_ready            transmit buffer empty
//   rx_data, rx_valid   received byte and its valid flag
//   rx_ack              consumer acknowledge, clears rx_valid
//   rx_overrun          sticky overrun flag
//   busy                transaction in progress
// Build option:
//   SPI_SLAVE_OVERRUN_EN  drop bytes arriving while rx_valid is pending and
//                         flag them on rx_overrun; otherwise rx_overrun = 0.

module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       busy
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   cpol_q, cpha_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   done_pend;
  logic [DATA_W-1:0]      rx_sr, tx_sr, tx_buf;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;
  logic lead_c, trail_c, sample_c, shift_c;
  logic start_idle_c, end_c, act_c;
  logic sample_hit_c, last_bit_c, byte_start_c, shift_out_c, mode0_start_c;
  logic [DATA_W-1:0] rx_byte_c, start_val_c;

  // Synchronisers plus one extra register for edge detection. cs resets to
  // "asserted" so a reset taken with cs low never fakes a fresh cs edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise_c = sclk_s & ~sclk_d;
  assign sclk_fall_c = ~sclk_s & sclk_d;
  assign cs_rise_c   = cs_s & ~cs_d;
  assign cs_fall_c   = ~cs_s & cs_d;

  // Mode decode: leading edge follows cpol, sample edge follows cpha.
  assign lead_c   = cpol_q ? sclk_fall_c : sclk_rise_c;
  assign trail_c  = cpol_q ? sclk_rise_c : sclk_fall_c;
  assign sample_c = cpha_q ? trail_c : lead_c;
  assign shift_c  = cpha_q ? lead_c : trail_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_HIGH;
    else     state <= next_state;
  end

  // Next-state logic and transaction start/end strobes
  always_comb begin
    next_state   = state;
    start_idle_c = 1'b0;
    end_c        = 1'b0;
    case (state)
      WAIT_HIGH: if (cs_s) next_state = IDLE;
      IDLE: begin
        if (cs_fall_c) begin
          next_state   = ACTIVE;
          start_idle_c = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise_c) begin
          next_state = IDLE;
          end_c      = 1'b1;
        end
      end
      default: next_state = WAIT_HIGH;
    endcase
  end

  // cs deassertion takes priority over any sclk edge in the same cycle.
  assign act_c        = (state == ACTIVE) && !cs_rise_c;
  assign sample_hit_c = act_c && sample_c;
  assign last_bit_c   = sample_hit_c && (bit_cnt == CNT_W'(DATA_W - 1));
  assign rx_byte_c    = {rx_sr[DATA_W-2:0], mosi_s};
  // cpha=0 starts the next byte on the shift edge after the 8th sample;
  // cpha=1 starts it on the 8th sample itself.
  assign byte_start_c = start_idle_c
                      | (act_c & cpha_q & last_bit_c)
                      | (act_c & ~cpha_q & shift_c & done_pend);
  assign shift_out_c  = act_c && shift_c && !(!cpha_q && done_pend);
  assign start_val_c  = tx_ready ? DATA_W'(0) : tx_buf;
  assign mode0_start_c = start_idle_c ? ~cpha : ~cpha_q;

  // Transaction control and receive shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      done_pend <= 1'b0;
      rx_sr     <= '0;
    end else begin
      if (start_idle_c) begin
        cpol_q    <= cpol;
        cpha_q    <= cpha;
        busy      <= 1'b1;
        bit_cnt   <= '0;
        done_pend <= 1'b0;
      end
      if (end_c) begin
        busy      <= 1'b0;
        bit_cnt   <= '0;
        done_pend <= 1'b0;
      end
      if (byte_start_c && !start_idle_c) done_pend <= 1'b0;
      if (sample_hit_c) begin
        rx_sr   <= rx_byte_c;
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (last_bit_c) done_pend <= ~cpha_q;
      end
    end
  end

  // Transmit buffer, transmit shift register and miso
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_buf   <= '0;
      tx_ready <= 1'b1;
      tx_sr    <= '0;
      miso     <= 1'b0;
    end else begin
      // A load coinciding with a byte start fills the buffer for the next byte.
      if (tx_load && tx_ready) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end else if (byte_start_c) begin
        tx_ready <= 1'b1;
      end

      if (end_c || (state != ACTIVE)) miso <= 1'b0;

      if (byte_start_c) begin
        if (mode0_start_c) begin
          miso  <= start_val_c[DATA_W-1];
          tx_sr <= {start_val_c[DATA_W-2:0], 1'b0};
        end else begin
          tx_sr <= start_val_c;
        end
      end else if (shift_out_c) begin
        miso  <= tx_sr[DATA_W-1];
        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  // Receive output: a byte arriving over an unacknowledged one is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_ack) rx_overrun <= 1'b0;
      if (last_bit_c) begin
        if (rx_valid && !rx_ack) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_data  <= rx_byte_c;
          rx_valid <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end
`else
  // Receive output: a new byte always overwrites rx_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (last_bit_c) begin
        rx_data  <= rx_byte_c;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: drives a bit-banged SPI master in all
// four modes and checks received bytes and the miso stream via scoreboards.

module tb_spi_slave;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst, cpol, cpha, sclk, cs, mosi, miso;
  logic [7:0] tx_data;
  logic       tx_load, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ack, rx_overrun, busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs(cs),
    .mosi(mosi), .miso(miso), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ack(rx_ack), .rx_overrun(rx_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sclk = pol;
    wait_clks(10);
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_data = b;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic ack_rx;
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  // Bounded wait for rx_valid; reports only whether it was seen.
  task automatic wait_rx(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rx_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Bit-banged master: shifts nbits of mo out, captures miso into mi.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = mo[7-i];
        wait_clks(HALF);
        mi[7-i] = miso;
        sclk = ~sclk;
        wait_clks(HALF);
        sclk = ~sclk;
      end else begin
        sclk = ~sclk;
        mosi = mo[7-i];
        wait_clks(HALF);
        mi[7-i] = miso;
        sclk = ~sclk;
        wait_clks(HALF);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_clks(4);
    n_cmp++;
    if ({miso, rx_valid, rx_overrun, tx_ready, busy} !== 5'b00010) begin
      n_err++;
      $display("FAIL reset_flags: miso/rx_valid/rx_overrun/tx_ready/busy=%b want 00010",
               {miso, rx_valid, rx_overrun, tx_ready, busy});
    end
    n_cmp++;
    if (rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_rx_data: got %h want 00", rx_data);
    end
    rst = 1'b0;
    wait_clks(6);
  endtask

  task automatic test_modes;
    logic [7:0] mi, e;
    bit seen;
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0]);
      load_tx(8'hA5);
      n_cmp++;
      if (tx_ready !== 1'b0) begin
        n_err++;
        $display("FAIL mode%0d_tx_ready_after_load: got %b want 0", m, tx_ready);
      end
      exp_rx.push_back(8'h3C);
      exp_tx.push_back(8'hA5);
      cs = 1'b0;
      wait_clks(HALF);
      n_cmp++;
      if ({busy, tx_ready} !== 2'b11) begin
        n_err++;
        $display("FAIL mode%0d_start: busy,tx_ready=%b want 11", m, {busy, tx_ready});
      end
      xfer(8'h3C, 8, mi);
      e = exp_tx.pop_front();
      n_cmp++;
      if (mi !== e) begin
        n_err++;
        $display("FAIL mode%0d_miso: got %h want %h", m, mi, e);
      end
      wait_rx(seen);
      e = exp_rx.pop_front();
      n_cmp++;
      if (!seen || rx_data !== e) begin
        n_err++;
        $display("FAIL mode%0d_rx: valid=%b data=%h want %h", m, seen, rx_data, e);
      end
      ack_rx();
      wait_clks(HALF);
      cs = 1'b1;
      wait_clks(HALF);
      n_cmp++;
      if ({busy, rx_valid} !== 2'b00) begin
        n_err++;
        $display("FAIL mode%0d_end: busy,rx_valid=%b want 00", m, {busy, rx_valid});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] mi, e;
    bit seen;
    set_mode(1'b0, 1'b0);
    load_tx(8'h5A);
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(8'h00);
    exp_rx.push_back(8'h01);
    exp_rx.push_back(8'h02);
    cs = 1'b0;
    wait_clks(HALF);
    for (int b = 0; b < 2; b++) begin
      xfer(8'(b + 1), 8, mi);
      e = exp_tx.pop_front();
      n_cmp++;
      if (mi !== e) begin
        n_err++;
        $display("FAIL burst%0d_miso: got %h want %h", b, mi, e);
      end
      wait_rx(seen);
      e = exp_rx.pop_front();
      n_cmp++;
      if (!seen || rx_data !== e) begin
        n_err++;
        $display("FAIL burst%0d_rx: valid=%b data=%h want %h", b, seen, rx_data, e);
      end
      ack_rx();
    end
    wait_clks(HALF);
    cs = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic test_abort;
    logic [7:0] mi, e;
    bit seen;
    set_mode(1'b0, 1'b0);
    cs = 1'b0;
    wait_clks(HALF);
    xfer(8'hE7, 5, mi);
    wait_clks(HALF);
    cs = 1'b1;
    wait_clks(12);
    n_cmp++;
    if ({busy, rx_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_state: busy,rx_valid=%b want 00", {busy, rx_valid});
    end
    exp_rx.push_back(8'h96);
    cs = 1'b0;
    wait_clks(HALF);
    xfer(8'h96, 8, mi);
    wait_rx(seen);
    e = exp_rx.pop_front();
    n_cmp++;
    if (!seen || rx_data !== e) begin
      n_err++;
      $display("FAIL abort_next_rx: valid=%b data=%h want %h", seen, rx_data, e);
    end
    ack_rx();
    wait_clks(HALF);
    cs = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic test_overrun;
    logic [7:0] mi, e;
    logic       eo;
`ifdef SPI_SLAVE_OVERRUN_EN
    e  = 8'h11;
    eo = 1'b1;
`else
    e  = 8'h22;
    eo = 1'b0;
`endif
    set_mode(1'b0, 1'b0);
    cs = 1'b0;
    wait_clks(HALF);
    xfer(8'h11, 8, mi);
    xfer(8'h22, 8, mi);
    wait_clks(HALF);
    cs = 1'b1;
    wait_clks(HALF);
    n_cmp++;
    if ({rx_valid, rx_overrun, rx_data} !== {1'b1, eo, e}) begin
      n_err++;
      $display("FAIL overrun: valid=%b ovr=%b data=%h want 1 %b %h",
               rx_valid, rx_overrun, rx_data, eo, e);
    end
    ack_rx();
    n_cmp++;
    if ({rx_valid, rx_overrun} !== 2'b00) begin
      n_err++;
      $display("FAIL overrun_ack: valid,ovr=%b want 00", {rx_valid, rx_overrun});
    end
  endtask

  task automatic test_rst_mid;
    logic [7:0] mi, e;
    bit seen;
    set_mode(1'b0, 1'b0);
    cs = 1'b0;
    wait_clks(HALF);
    xfer(8'hF0, 4, mi);
    load_tx(8'h77);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({miso, rx_valid, rx_overrun, tx_ready, busy, rx_data} !== {5'b00010, 8'h00}) begin
      n_err++;
      $display("FAIL rst_mid_values: flags=%b rx_data=%h want 00010 00",
               {miso, rx_valid, rx_overrun, tx_ready, busy}, rx_data);
    end
    xfer(8'hFF, 8, mi);
    wait_clks(HALF);
    n_cmp++;
    if ({busy, rx_valid, miso, mi} !== {3'b000, 8'h00}) begin
      n_err++;
      $display("FAIL rst_mid_quiet: busy,rx_valid,miso=%b miso_byte=%h want 000 00",
               {busy, rx_valid, miso}, mi);
    end
    cs = 1'b1;
    wait_clks(12);
    exp_rx.push_back(8'hC3);
    exp_tx.push_back(8'h00);
    cs = 1'b0;
    wait_clks(HALF);
    xfer(8'hC3, 8, mi);
    e = exp_tx.pop_front();
    n_cmp++;
    if (mi !== e) begin
      n_err++;
      $display("FAIL rst_mid_next_miso: got %h want %h", mi, e);
    end
    wait_rx(seen);
    e = exp_rx.pop_front();
    n_cmp++;
    if (!seen || rx_data !== e) begin
      n_err++;
      $display("FAIL rst_mid_next_rx: valid=%b data=%h want %h", seen, rx_data, e);
    end
    ack_rx();
    wait_clks(HALF);
    cs = 1'b1;
    wait_clks(HALF);
  endtask

  initial begin
    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_load = 1'b0; rx_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_modes();
    test_back_to_back();
    test_abort();
    test_overrun();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
